// File: rtl/bin2bcd_display.sv
// Binary-to-BCD converter for an 8-digit 7-segment display: double-dabble conversion,
// leading-zero blanking and overflow dashes, with outputs updated once per conversion.
module bin2bcd_display #(
    parameter int          BLANK_LEADING = 1,
    parameter logic [4:0]  OVF_CODE      = 5'd22
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [26:0] value,
    input  logic [7:0]  dp_in,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [4:0]  d0,
    output logic [4:0]  d1,
    output logic [4:0]  d2,
    output logic [4:0]  d3,
    output logic [4:0]  d4,
    output logic [4:0]  d5,
    output logic [4:0]  d6,
    output logic [4:0]  d7,
    output logic [7:0]  dp
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_FORMAT  = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [4:0]  BLANK_CODE = 5'd23;
    localparam logic [39:0] DISP_RESET = {{7{BLANK_CODE}}, 5'd0};

    logic [1:0]  state_r;
    logic [4:0]  cnt_r;
    logic [26:0] bin_r;
    logic [31:0] bcd_r;
    logic        ovf_r;
    logic [7:0]  dp_cap_r;
    logic [39:0] stage_r;
    logic [7:0]  stage_dp_r;
    logic [39:0] disp_r;
    logic [7:0]  dp_r;
    logic        busy_r;
    logic        done_r;

    // One shift-add-3 iteration on the combined {bcd, bin} register.
    function automatic logic [58:0] dd_step(input logic [31:0] bcd, input logic [26:0] bin);
        logic [31:0] adj;
        adj = bcd;
        for (int i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = bcd[4*i +: 4];
            end
        end
        return {adj[30:0], bin, 1'b0};
    endfunction

    // Map BCD nibbles to digit codes; blanking walks down from d7 until the first non-zero nibble.
    function automatic logic [39:0] format_digits(input logic [31:0] bcd, input logic ovf);
        logic [39:0] dig;
        logic        lead;
        dig  = {8{OVF_CODE}};
        lead = 1'b1;
        if (!ovf) begin
            for (int i = 7; i >= 1; i--) begin
                if (bcd[4*i +: 4] != 4'd0) begin
                    lead = 1'b0;
                end else begin
                    lead = lead;
                end
                if (lead && (BLANK_LEADING != 0)) begin
                    dig[5*i +: 5] = BLANK_CODE;
                end else begin
                    dig[5*i +: 5] = {1'b0, bcd[4*i +: 4]};
                end
            end
            dig[4:0] = {1'b0, bcd[3:0]};
        end else begin
            dig = {8{OVF_CODE}};
        end
        return dig;
    endfunction

    // Conversion sequencer: capture, 27 dabble steps, format into staging, then publish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 5'd0;
            bin_r      <= 27'd0;
            bcd_r      <= 32'd0;
            ovf_r      <= 1'b0;
            dp_cap_r   <= 8'h00;
            stage_r    <= DISP_RESET;
            stage_dp_r <= 8'h00;
            disp_r     <= DISP_RESET;
            dp_r       <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        bin_r    <= value;
                        dp_cap_r <= dp_in;
                        ovf_r    <= (value > 27'd99_999_999);
                        bcd_r    <= 32'd0;
                        cnt_r    <= 5'd26;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CONVERT;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                ST_CONVERT: begin
                    {bcd_r, bin_r} <= dd_step(bcd_r, bin_r);
                    if (cnt_r == 5'd0) begin
                        state_r <= ST_FORMAT;
                    end else begin
                        cnt_r   <= cnt_r - 5'd1;
                    end
                end
                ST_FORMAT: begin
                    stage_r    <= format_digits(bcd_r, ovf_r);
                    stage_dp_r <= dp_cap_r;
                    busy_r     <= 1'b0;
                    state_r    <= ST_DONE;
                end
                ST_DONE: begin
                    disp_r  <= stage_r;
                    dp_r    <= stage_dp_r;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = ovf_r;
    assign dp       = dp_r;
    assign d0       = disp_r[4:0];
    assign d1       = disp_r[9:5];
    assign d2       = disp_r[14:10];
    assign d3       = disp_r[19:15];
    assign d4       = disp_r[24:20];
    assign d5       = disp_r[29:25];
    assign d6       = disp_r[34:30];
    assign d7       = disp_r[39:35];

endmodule

// File: tb/tb_bin2bcd_display.sv
// Directed self-checking bench for bin2bcd_display: latency, formatting, overflow,
// reset abort and back-to-back operation, with a second instance for BLANK_LEADING=0.
module tb_bin2bcd_display;

    logic        clk;
    logic        reset;
    logic        start;
    logic [26:0] value;
    logic [7:0]  dp_in;

    logic        busy_b, done_b, ovf_b;
    logic [4:0]  d0_b, d1_b, d2_b, d3_b, d4_b, d5_b, d6_b, d7_b;
    logic [7:0]  dp_b;
    logic        busy_n, done_n, ovf_n;
    logic [4:0]  d0_n, d1_n, d2_n, d3_n, d4_n, d5_n, d6_n, d7_n;
    logic [7:0]  dp_n;

    logic [39:0] disp_b;
    logic [39:0] disp_n;
    assign disp_b = {d7_b, d6_b, d5_b, d4_b, d3_b, d2_b, d1_b, d0_b};
    assign disp_n = {d7_n, d6_n, d5_n, d4_n, d3_n, d2_n, d1_n, d0_n};

    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] prev_exp;

    localparam logic [39:0] RST_DISP = {{7{5'd23}}, 5'd0};

    bin2bcd_display #(.BLANK_LEADING(1), .OVF_CODE(5'd22)) u_dut (
        .clk(clk), .reset(reset), .start(start), .value(value), .dp_in(dp_in),
        .busy(busy_b), .done(done_b), .overflow(ovf_b),
        .d0(d0_b), .d1(d1_b), .d2(d2_b), .d3(d3_b), .d4(d4_b), .d5(d5_b), .d6(d6_b), .d7(d7_b),
        .dp(dp_b)
    );

    bin2bcd_display #(.BLANK_LEADING(0), .OVF_CODE(5'd22)) u_dut_nb (
        .clk(clk), .reset(reset), .start(start), .value(value), .dp_in(dp_in),
        .busy(busy_n), .done(done_n), .overflow(ovf_n),
        .d0(d0_n), .d1(d1_n), .d2(d2_n), .d3(d3_n), .d4(d4_n), .d5(d5_n), .d6(d6_n), .d7(d7_n),
        .dp(dp_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One full conversion with cycle-accurate checks of busy, done and output timing.
    task automatic run_conv(input string tag, input logic [26:0] v, input logic [7:0] dpv,
                            input logic exp_ovf, input logic [39:0] exp_disp);
        logic early_done;
        early_done = 1'b0;
        @(negedge clk);
        value = v;
        dp_in = dpv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_N"}, {39'd0, busy_b}, 40'd1);
        check({tag, "_ovf_N"}, {39'd0, ovf_b}, {39'd0, exp_ovf});
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk);
            #1;
            if (done_b) early_done = 1'b1;
            if (k == 27) check({tag, "_busy_N27"}, {39'd0, busy_b}, 40'd1);
        end
        check({tag, "_busy_N28"}, {39'd0, busy_b}, 40'd0);
        check({tag, "_early_done"}, {39'd0, early_done}, 40'd0);
        check({tag, "_disp_hold_N28"}, disp_b, prev_exp);
        @(posedge clk);
        #1;
        check({tag, "_done_N29"}, {39'd0, done_b}, 40'd1);
        check({tag, "_disp"}, disp_b, exp_disp);
        check({tag, "_dp"}, {32'd0, dp_b}, {32'd0, dpv});
        prev_exp = exp_disp;
        @(posedge clk);
        #1;
        check({tag, "_done_N30"}, {39'd0, done_b}, 40'd0);
    endtask

    initial begin
        int dcount;
        int dfirst;
        int dlast;
        logic gap_bad;
        logic saw_done;

        reset = 1'b0;
        start = 1'b0;
        value = 27'd0;
        dp_in = 8'h00;
        prev_exp = RST_DISP;

        // Start held high through reset must not be taken.
        @(negedge clk);
        start = 1'b1;
        value = 27'd777;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {39'd0, busy_b}, 40'd0);
        check("rst_done", {39'd0, done_b}, 40'd0);
        check("rst_ovf", {39'd0, ovf_b}, 40'd0);
        check("rst_disp", disp_b, RST_DISP);
        check("rst_dp", {32'd0, dp_b}, 40'd0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_busy", {39'd0, busy_b}, 40'd0);

        run_conv("v12345678", 27'd12_345_678, 8'h04, 1'b0,
                 {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8});
        run_conv("v0", 27'd0, 8'h00, 1'b0, RST_DISP);
        run_conv("v99999999", 27'd99_999_999, 8'h81, 1'b0, {8{5'd9}});
        run_conv("v305", 27'd305, 8'hFF, 1'b0, {{5{5'd23}}, 5'd3, 5'd0, 5'd5});
        check("v305_noblank", disp_n, {{5{5'd0}}, 5'd3, 5'd0, 5'd5});
        run_conv("v1000", 27'd1000, 8'h10, 1'b0, {{4{5'd23}}, 5'd1, 5'd0, 5'd0, 5'd0});
        run_conv("vovf", 27'd100_000_000, 8'hA5, 1'b1, {8{5'd22}});
        check("vovf_noblank", disp_n, {8{5'd22}});

        // Abort: start at N, ignored start at N+5, reset at N+10.
        @(negedge clk);
        value = 27'd4321;
        dp_in = 8'h0F;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        value = 27'd55;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done_b) saw_done = 1'b1;
        end
        check("abort_no_done", {39'd0, saw_done}, 40'd0);
        check("abort_disp", disp_b, RST_DISP);
        check("abort_dp", {32'd0, dp_b}, 40'd0);
        check("abort_ovf", {39'd0, ovf_b}, 40'd0);
        prev_exp = RST_DISP;
        run_conv("after_abort", 27'd12_345_678, 8'h04, 1'b0,
                 {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8});

        // Back-to-back with start held high: done every 30 clocks.
        @(negedge clk);
        value = 27'd42;
        dp_in = 8'h02;
        start = 1'b1;
        @(posedge clk);
        dcount = 0;
        dfirst = 0;
        dlast = 0;
        gap_bad = 1'b0;
        for (int c = 1; c <= 89; c++) begin
            @(posedge clk);
            #1;
            if (done_b) begin
                if (dcount == 0) dfirst = c;
                else if (c - dlast != 30) gap_bad = 1'b1;
                dlast = c;
                dcount++;
            end
        end
        start = 1'b0;
        check("b2b_count", dcount, 40'd3);
        check("b2b_first", dfirst, 40'd29);
        check("b2b_gap", {39'd0, gap_bad}, 40'd0);
        check("b2b_disp", disp_b, {{6{5'd23}}, 5'd4, 5'd2});
        @(posedge clk);
        #1;
        check("b2b_idle", {39'd0, busy_b}, 40'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
